// File: rtl/layer1_maxpool.sv
// layer1_maxpool: 2x2 stride-2 max pool over LANES-wide signed pixels arriving in raster order.
// Optional build macro LAYER1_MAXPOOL_RELU_EN clamps negative input lanes to zero before pooling.
module layer1_maxpool #(
    parameter int IN_ROWS = 30,
    parameter int IN_COLS = 30,
    parameter int LANES   = 8,
    parameter int LANE_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      in_valid,
    input  logic [LANES*LANE_W-1:0]   in_data,
    output logic                      out_valid,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [15:0]               out_row,
    output logic [15:0]               out_col,
    output logic                      pool_done
);
    localparam int W     = LANES * LANE_W;
    localparam int BUF_N = (IN_COLS / 2 > 0) ? IN_COLS / 2 : 1;
    localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

    localparam logic [15:0] COL_LAST     = 16'(IN_COLS - 1);
    localparam logic [15:0] ROW_LAST     = 16'(IN_ROWS - 1);
    localparam logic [15:0] OUT_ROW_LAST = 16'(IN_ROWS / 2 - 1);
    localparam logic [15:0] OUT_COL_LAST = 16'(IN_COLS / 2 - 1);

    function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]             m;
        logic signed [LANE_W-1:0] la;
        logic signed [LANE_W-1:0] lb;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            la = a[k*LANE_W +: LANE_W];
            lb = b[k*LANE_W +: LANE_W];
            m[k*LANE_W +: LANE_W] = (la >= lb) ? la : lb;
        end
        return m;
    endfunction

`ifdef LAYER1_MAXPOOL_RELU_EN
    function automatic logic [W-1:0] relu_clamp(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = a;
        for (int k = 0; k < LANES; k++) begin
            if (a[k*LANE_W + LANE_W - 1])
                r[k*LANE_W +: LANE_W] = '0;
        end
        return r;
    endfunction
`endif

    logic [15:0]      col_cnt;
    logic [15:0]      row_cnt;
    logic [W-1:0]     hold_reg;
    logic [W-1:0]     line_buf [BUF_N];

    logic [W-1:0]     pix;
    logic [W-1:0]     hmax;
    logic [W-1:0]     vmax;
    logic [15:0]      col_half;
    logic [15:0]      row_half;
    logic [IDX_W-1:0] buf_idx;

`ifdef LAYER1_MAXPOOL_RELU_EN
    assign pix = relu_clamp(in_data);
`else
    assign pix = in_data;
`endif

    assign col_half = col_cnt >> 1;
    assign row_half = row_cnt >> 1;
    assign buf_idx  = col_half[IDX_W-1:0];
    assign hmax     = lane_max(hold_reg, pix);
    assign vmax     = lane_max(line_buf[buf_idx], hmax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            hold_reg  <= '0;
            for (int i = 0; i < BUF_N; i++)
                line_buf[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            pool_done <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            pool_done <= 1'b0;
            // frame_start discards any partially accumulated window and drops a coincident pixel
            if (frame_start) begin
                col_cnt  <= '0;
                row_cnt  <= '0;
                hold_reg <= '0;
                for (int i = 0; i < BUF_N; i++)
                    line_buf[i] <= '0;
            end else if (in_valid) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? 16'd0 : row_cnt + 16'd1;
                end else begin
                    col_cnt <= col_cnt + 16'd1;
                end

                // odd trailing col/row never reach the emit branch, so they fall out naturally
                if (!col_cnt[0]) begin
                    hold_reg <= pix;
                end else if (!row_cnt[0]) begin
                    line_buf[buf_idx] <= hmax;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= vmax;
                    out_row   <= row_half;
                    out_col   <= col_half;
                    pool_done <= (row_half == OUT_ROW_LAST) && (col_half == OUT_COL_LAST);
                end
            end
        end
    end
endmodule
